// File: rtl/ram_sdp_clr.sv
// Simple-dual-port RAM with byte enables, 1/2-cycle read latency and clear engine.
// Ports: clk, rst (async high), clr_req/busy, write wren/wr_addr/wr_data/wr_be, read rden/rd_addr/q/q_valid.
module ram_sdp_clr #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter bit OUT_REG = 1'b0,
  parameter bit RDW_NEW = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_req,
  output logic                    busy,
  input  logic                    wren,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rden,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    q_valid
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int BE_WIDTH = DATA_WIDTH/8;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [BE_WIDTH-1:0]   mem_be;

  logic                  rd_go;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  v1;
  logic [DATA_WIDTH-1:0] d1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_CLEAR: if (&clr_cnt) state_nxt = S_IDLE;
      S_IDLE:  if (clr_req)  state_nxt = S_CLEAR;
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    busy  = (state == S_CLEAR);
    rd_go = rden && (state == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      clr_cnt <= '0;
    else if (state == S_CLEAR)
      clr_cnt <= clr_cnt + 1'b1;
  end

  // The sweep owns the write port; user writes only land when idle.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wr_addr;
    mem_wd = wr_data;
    mem_be = wr_be;
    if (state == S_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = clr_cnt;
      mem_wd = CLR_VALUE;
      mem_be = '1;
    end else if (wren) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (mem_be[i])
          mem[mem_wa][8*i +: 8] <= mem_wd[8*i +: 8];
      end
    end
  end

  // Same-address bypass: merge the enabled write bytes over the old word.
  always_comb begin
    rd_word = mem[rd_addr];
    if (RDW_NEW && wren && (wr_addr == rd_addr)) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (wr_be[i])
          rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= rd_go;
      if (rd_go) d1 <= rd_word;
    end
  end

  generate
    if (OUT_REG) begin : g_oreg
      logic                  v2;
      logic [DATA_WIDTH-1:0] d2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end

      assign q       = d2;
      assign q_valid = v2;
    end else begin : g_noreg
      assign q       = d1;
      assign q_valid = v1;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Bench for ram_sdp_clr: two instances (8-bit/latency1/new-data/clr 00 and
// 32-bit/latency2/old-data/clr ffffffff) driven by one shared stimulus.
module tb_ram_sdp_clr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_req = 1'b0;
  logic        wren = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rden = 1'b0;
  logic [7:0]  rd_addr = '0;

  logic        busy_a, qv_a;
  logic [7:0]  q_a;
  logic        busy_b, qv_b;
  logic [31:0] q_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_sdp_clr #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .OUT_REG(1'b0),
    .RDW_NEW(1'b1), .CLR_VALUE(8'h00)
  ) dut_a (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a),
    .wren(wren), .wr_addr(wr_addr), .wr_data(wr_data[7:0]),
    .wr_be(wr_be[0]), .rden(rden), .rd_addr(rd_addr),
    .q(q_a), .q_valid(qv_a)
  );

  ram_sdp_clr #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .OUT_REG(1'b1),
    .RDW_NEW(1'b0), .CLR_VALUE(32'hffff_ffff)
  ) dut_b (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b),
    .wren(wren), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rden(rden), .rd_addr(rd_addr),
    .q(q_b), .q_valid(qv_b)
  );

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [7:0]  ra;
    logic        va;
    logic [7:0]  qa;
    logic        vb;
    logic [31:0] qb;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic we, input logic [7:0] wa, input logic [31:0] wd,
    input logic [3:0] be, input logic re, input logic [7:0] ra,
    input logic va, input logic [7:0] qa,
    input logic vb, input logic [31:0] qb
  );
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.be = be;
    v.re = re; v.ra = ra; v.va = va; v.qa = qa;
    v.vb = vb; v.qb = qb;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    clr_req = 1'b0; wren = 1'b0; rden = 1'b0;
    wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
  endtask

  task automatic wait_idle(output int n, output int nv);
    n = 0;
    nv = 0;
    while ((busy_a || busy_b) && n < 400) begin
      step();
      n++;
      if (qv_a || qv_b) nv++;
    end
  endtask

  int n, nv;
  logic [7:0] probe [4];

  initial begin
    // reset
    step();
    step();
    chk("rst busy_a", busy_a, 1);
    chk("rst busy_b", busy_b, 1);
    chk("rst q_a", q_a, 0);
    chk("rst qv_a", qv_a, 0);
    chk("rst q_b", q_b, 0);
    chk("rst qv_b", qv_b, 0);
    rst = 1'b0;
    wait_idle(n, nv);
    chk("init sweep len", n, 256);
    chk("init sweep qv", nv, 0);

    // table: reads after clear, pipelined reads, byte enables, rdw
    add(0, 0, 32'h0, 4'h0, 1, 0,   1, 8'h00, 0, 32'h0);
    add(0, 0, 32'h0, 4'h0, 1, 128, 1, 8'h00, 1, 32'hffffffff);
    add(0, 0, 32'h0, 4'h0, 1, 255, 1, 8'h00, 1, 32'hffffffff);
    add(0, 0, 32'h0, 4'h0, 0, 0,   0, 8'h00, 1, 32'hffffffff);
    add(1, 0, 32'h112233ab, 4'hf, 0, 0, 0, 8'h00, 0, 32'hffffffff);
    add(1, 1, 32'h445566bb, 4'hf, 0, 0, 0, 8'h00, 0, 32'hffffffff);
    add(1, 2, 32'h778899cc, 4'hf, 0, 0, 0, 8'h00, 0, 32'hffffffff);
    add(0, 0, 32'h0, 4'h0, 1, 0, 1, 8'hab, 0, 32'hffffffff);
    add(0, 0, 32'h0, 4'h0, 1, 1, 1, 8'hbb, 1, 32'h112233ab);
    add(0, 0, 32'h0, 4'h0, 1, 2, 1, 8'hcc, 1, 32'h445566bb);
    add(0, 0, 32'h0, 4'h0, 0, 0, 0, 8'hcc, 1, 32'h778899cc);
    add(1, 5, 32'h11223344, 4'hf, 0, 0, 0, 8'hcc, 0, 32'h778899cc);
    add(1, 5, 32'haabbccdd, 4'h5, 0, 0, 0, 8'hcc, 0, 32'h778899cc);
    add(0, 0, 32'h0, 4'h0, 1, 5, 1, 8'hdd, 0, 32'h778899cc);
    add(0, 0, 32'h0, 4'h0, 0, 0, 0, 8'hdd, 1, 32'h11bb33dd);
    add(1, 5, 32'h0, 4'h0, 0, 0, 0, 8'hdd, 0, 32'h11bb33dd);
    add(0, 0, 32'h0, 4'h0, 1, 5, 1, 8'hdd, 0, 32'h11bb33dd);
    add(0, 0, 32'h0, 4'h0, 0, 0, 0, 8'hdd, 1, 32'h11bb33dd);
    add(1, 7, 32'h000000cc, 4'hf, 0, 0, 0, 8'hdd, 0, 32'h11bb33dd);
    add(1, 7, 32'h0000005a, 4'hf, 1, 7, 1, 8'h5a, 0, 32'h11bb33dd);
    add(0, 0, 32'h0, 4'h0, 1, 7, 1, 8'h5a, 1, 32'h000000cc);
    add(0, 0, 32'h0, 4'h0, 0, 0, 0, 8'h5a, 1, 32'h0000005a);
    add(1, 9, 32'h00000077, 4'hf, 1, 8, 1, 8'h00, 0, 32'h0000005a);
    add(0, 0, 32'h0, 4'h0, 0, 0, 0, 8'h00, 1, 32'hffffffff);

    foreach (vq[i]) begin
      wren = vq[i].we; wr_addr = vq[i].wa;
      wr_data = vq[i].wd; wr_be = vq[i].be;
      rden = vq[i].re; rd_addr = vq[i].ra;
      step();
      chk($sformatf("row%0d qv_a", i), qv_a, vq[i].va);
      chk($sformatf("row%0d q_a", i), q_a, vq[i].qa);
      chk($sformatf("row%0d qv_b", i), qv_b, vq[i].vb);
      chk($sformatf("row%0d q_b", i), q_b, vq[i].qb);
    end
    idle_in();

    // clr_req with a same-cycle read, then traffic during busy
    clr_req = 1'b1; rden = 1'b1; rd_addr = 8'd0;
    step();
    chk("clr acc qv_a", qv_a, 1);
    chk("clr acc q_a", q_a, 8'hab);
    chk("clr acc busy_a", busy_a, 1);
    chk("clr acc busy_b", busy_b, 1);
    clr_req = 1'b0;
    wren = 1'b1; wr_addr = 8'd3; wr_data = 32'h12121212; wr_be = 4'hf;
    step();
    chk("clr inflight qv_b", qv_b, 1);
    chk("clr inflight q_b", q_b, 32'h112233ab);
    chk("clr +1 qv_a", qv_a, 0);
    wait_idle(n, nv);
    idle_in();
    chk("clr sweep len", n, 255);
    chk("clr sweep qv", nv, 0);
    chk("clr done busy_b", busy_b, 0);

    probe[0] = 8'd0; probe[1] = 8'd3;
    probe[2] = 8'd128; probe[3] = 8'd255;
    for (int i = 0; i < 5; i++) begin
      rden = (i < 4);
      rd_addr = (i < 4) ? probe[i] : 8'd0;
      step();
      if (i < 4) begin
        chk($sformatf("probe%0d qv_a", i), qv_a, 1);
        chk($sformatf("probe%0d q_a", i), q_a, 8'h00);
      end
      if (i > 0) begin
        chk($sformatf("probe%0d qv_b", i - 1), qv_b, 1);
        chk($sformatf("probe%0d q_b", i - 1), q_b, 32'hffffffff);
      end
    end
    idle_in();

    // reset ten cycles into a sweep
    wren = 1'b1; wr_addr = 8'd10; wr_data = 32'h5a5a5a5a; wr_be = 4'hf;
    step();
    idle_in();
    clr_req = 1'b1; rden = 1'b1; rd_addr = 8'd10;
    step();
    idle_in();
    chk("mid q_a", q_a, 8'h5a);
    repeat (10) step();
    chk("mid busy_a", busy_a, 1);
    chk("mid hold q_a", q_a, 8'h5a);
    chk("mid hold q_b", q_b, 32'h5a5a5a5a);
    rst = 1'b1;
    #1;
    chk("mid rst q_a", q_a, 0);
    chk("mid rst qv_a", qv_a, 0);
    chk("mid rst q_b", q_b, 0);
    chk("mid rst qv_b", qv_b, 0);
    chk("mid rst busy_b", busy_b, 1);
    step();
    step();
    rst = 1'b0;
    wait_idle(n, nv);
    chk("mid sweep len", n, 256);
    chk("mid sweep qv", nv, 0);

    // reset with a latency-2 read in flight
    rden = 1'b1; rd_addr = 8'd10;
    step();
    idle_in();
    chk("fl qv_a", qv_a, 1);
    chk("fl q_a", q_a, 8'h00);
    rst = 1'b1;
    #1;
    chk("fl rst qv_b", qv_b, 0);
    chk("fl rst q_b", q_b, 0);
    step();
    step();
    chk("fl lost qv_b", qv_b, 0);
    rst = 1'b0;
    wait_idle(n, nv);
    chk("fl sweep len", n, 256);
    chk("fl sweep qv", nv, 0);

    rden = 1'b1; rd_addr = 8'd10;
    step();
    idle_in();
    chk("fin qv_a", qv_a, 1);
    chk("fin q_a", q_a, 8'h00);
    step();
    chk("fin qv_b", qv_b, 1);
    chk("fin q_b", q_b, 32'hffffffff);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
